// File: rtl/display_pkg.sv
// Shared types and segment patterns for the multiplexed seven-segment display driver.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } conv_state_t;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        pat = SEG_BLANK;
        if (nib <= 4'd9) pat = SEG_LUT[nib];
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary to BCD converter.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned WORD_W     = 8,
    parameter int unsigned NUM_DIGITS = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WORD_W-1:0]       bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned SR_W  = BCD_W + WORD_W;
    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    conv_state_t       state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d, sr_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        sr_adj  = sr_q;

        // Pre-correct each BCD nibble so the following shift carries correctly
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (sr_q[WORD_W+4*i +: 4] >= 4'd5)
                sr_adj[WORD_W+4*i +: 4] = sr_q[WORD_W+4*i +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {BCD_W'(0), bin};
                    cnt_d   = CNT_W'(WORD_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {sr_adj[SR_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = LATCH;
            end
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == LATCH);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg_display_driver.sv
// Shows an unsigned register value in decimal on a multiplexed common-anode display:
// change detection, BCD conversion, atomic display latch, digit scanner and decode.
module seg_display_driver
    import display_pkg::*;
#(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned NUM_DIGITS  = 3,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WORD_W-1:0]     digits,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy
);

    localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
    localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if ((64'(10) ** NUM_DIGITS) <= ((64'(1) << WORD_W) - 64'(1))) begin : g_digits_chk
        $error("NUM_DIGITS too small to show every WORD_W value");
    end
    if (REFRESH_DIV < 1) begin : g_refresh_chk
        $error("REFRESH_DIV must be at least 1");
    end

    logic [WORD_W-1:0]  src_q, src_d;
    logic [BCD_W-1:0]   bcd_disp_q, bcd_disp_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               start_c;
    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic [3:0]         cur_nib;
    logic               upper_zero;

    bin2bcd_seq #(
        .WORD_W     (WORD_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (start_c),
        .bin   (digits),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_q      <= '0;
            bcd_disp_q <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
        end else begin
            src_q      <= src_d;
            bcd_disp_q <= bcd_disp_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
        end
    end

    // Change detection, display latch and free-running scanner
    always_comb begin
        src_d      = src_q;
        bcd_disp_d = bcd_disp_q;
        presc_d    = presc_q + PRESC_W'(1);
        idx_d      = idx_q;

        start_c = !conv_busy && (digits != src_q);
        if (start_c)   src_d      = digits;
        if (conv_done) bcd_disp_d = conv_bcd;

        if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Decode the lit digit; blank it when it and every higher digit are zero
    always_comb begin
        cur_nib    = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (IDX_W'(i) == idx_q) cur_nib = bcd_disp_q[4*i +: 4];
            if (IDX_W'(i) >= idx_q && bcd_disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end

        if (BLANK_LZ && idx_q != '0 && upper_zero) seg = SEG_BLANK;
        else                                       seg = seg_decode(cur_nib);

        an = ~(NUM_DIGITS'(1) << idx_q);
    end

    assign busy = conv_busy;

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver with REFRESH_DIV=4 and both blanking modes.
module tb_seg_display_driver;

    localparam int unsigned WORD_W      = 8;
    localparam int unsigned NUM_DIGITS  = 3;
    localparam int unsigned REFRESH_DIV = 4;
    localparam int          CONV_CYCLES = WORD_W + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [WORD_W-1:0] digits = '0;
    logic [6:0]        seg, seg_nb;
    logic [2:0]        an, an_nb;
    logic              busy, busy_nb;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    logic [6:0] obs_seg[3];
    logic [2:0] obs_an[3];
    int         obs_cnt[3];
    logic [2:0] obs_wrap;
    bit         scan_ok;

    seg_display_driver #(
        .WORD_W(WORD_W), .NUM_DIGITS(NUM_DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_LZ(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .digits(digits), .seg(seg), .an(an), .busy(busy)
    );

    seg_display_driver #(
        .WORD_W(WORD_W), .NUM_DIGITS(NUM_DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_LZ(1'b0)
    ) dut_nb (
        .clock(clock), .reset(reset), .digits(digits), .seg(seg_nb), .an(an_nb), .busy(busy_nb)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] model_seg(input int value, input int d, input bit blz);
        int p;
        int nib;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        nib = (value / p) % 10;
        if (blz && d > 0 && value < p) return 7'b1111111;
        case (nib)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 5 && !ok; k++) begin
            @(negedge clock);
            if (busy === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clock);
        end
    endtask

    // Align to the start of digit 0 and record one full scan cycle
    task automatic capture_scan(input bit nb);
        logic [2:0] prev;
        logic [2:0] cur_an;
        bit         found;
        found = 1'b0;
        prev  = nb ? an_nb : an;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clock);
            cur_an = nb ? an_nb : an;
            if (prev == 3'b011 && cur_an == 3'b110) found = 1'b1;
            prev = cur_an;
        end
        scan_ok = found;
        for (int d = 0; d < 3; d++) begin
            obs_an[d]  = nb ? an_nb : an;
            obs_seg[d] = nb ? seg_nb : seg;
            obs_cnt[d] = 0;
            while ((nb ? an_nb : an) == obs_an[d] && obs_cnt[d] < 20) begin
                if ((nb ? seg_nb : seg) != obs_seg[d]) obs_seg[d] = 7'bx;
                obs_cnt[d]++;
                @(negedge clock);
            end
        end
        obs_wrap = nb ? an_nb : an;
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_vec++; if (seg !== 7'b1000000) begin n_err++; $display("FAIL reset_seg: got %b want 1000000", seg); end
        n_vec++; if (an !== 3'b110) begin n_err++; $display("FAIL reset_an: got %b want 110", an); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        repeat (10) @(negedge clock);
        n_vec++; if (an !== 3'b110) begin n_err++; $display("FAIL reset_hold_an: got %b want 110", an); end
        reset = 1'b0;
        begin
            bit seen_busy;
            seen_busy = 1'b0;
            repeat (6) begin
                @(negedge clock);
                if (busy !== 1'b0) seen_busy = 1'b1;
            end
            n_vec++; if (seen_busy) begin n_err++; $display("FAIL reset_no_conv: got busy=1 want busy=0 for value 0"); end
        end
    endtask

    task automatic test_convert_255();
        bit ok;
        int n;
        int v;
        logic [2:0] exp_an;
        digits = 8'd255;
        exp_q.push_back(255);
        wait_rise(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL c255_rise: got busy=0 want busy=1"); end
        count_high(n);
        n_vec++; if (n != CONV_CYCLES) begin n_err++; $display("FAIL c255_busy_len: got %0d want %0d", n, CONV_CYCLES); end
        v = exp_q.pop_front();
        capture_scan(1'b0);
        n_vec++; if (!scan_ok) begin n_err++; $display("FAIL c255_scan_align: got no 011->110 want wrap seen"); end
        for (int d = 0; d < 3; d++) begin
            exp_an = ~(3'b001 << d);
            n_vec++; if (obs_seg[d] !== model_seg(v, d, 1'b1)) begin n_err++; $display("FAIL c255_seg%0d: got %b want %b", d, obs_seg[d], model_seg(v, d, 1'b1)); end
            n_vec++; if (obs_an[d] !== exp_an) begin n_err++; $display("FAIL c255_an%0d: got %b want %b", d, obs_an[d], exp_an); end
            n_vec++; if (obs_cnt[d] != int'(REFRESH_DIV)) begin n_err++; $display("FAIL c255_dwell%0d: got %0d want %0d", d, obs_cnt[d], REFRESH_DIV); end
        end
        n_vec++; if (obs_wrap !== 3'b110) begin n_err++; $display("FAIL c255_wrap: got %b want 110", obs_wrap); end
    endtask

    task automatic test_blanking();
        bit ok;
        int n;
        int v;
        digits = 8'd7;
        exp_q.push_back(7);
        wait_rise(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL blank_rise: got busy=0 want busy=1"); end
        count_high(n);
        n_vec++; if (n != CONV_CYCLES) begin n_err++; $display("FAIL blank_busy_len: got %0d want %0d", n, CONV_CYCLES); end
        v = exp_q.pop_front();
        capture_scan(1'b0);
        for (int d = 0; d < 3; d++) begin
            n_vec++; if (obs_seg[d] !== model_seg(v, d, 1'b1)) begin n_err++; $display("FAIL blank_lz1_seg%0d: got %b want %b", d, obs_seg[d], model_seg(v, d, 1'b1)); end
        end
        capture_scan(1'b1);
        n_vec++; if (!scan_ok) begin n_err++; $display("FAIL blank_lz0_align: got no 011->110 want wrap seen"); end
        for (int d = 0; d < 3; d++) begin
            n_vec++; if (obs_seg[d] !== model_seg(v, d, 1'b0)) begin n_err++; $display("FAIL blank_lz0_seg%0d: got %b want %b", d, obs_seg[d], model_seg(v, d, 1'b0)); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        int v;
        int idx;
        digits = 8'd255;
        exp_q.push_back(255);
        wait_rise(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_rise: got busy=0 want busy=1"); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 3) begin
                digits = 8'd12;
                exp_q.push_back(12);
            end
            @(negedge clock);
        end
        n_vec++; if (n != CONV_CYCLES) begin n_err++; $display("FAIL b2b_first_len: got %0d want %0d", n, CONV_CYCLES); end
        v = exp_q.pop_front();
        idx = -1;
        for (int i = 0; i < 3; i++) if (an[i] === 1'b0) idx = i;
        n_vec++;
        if (idx < 0 || seg !== model_seg(v, idx, 1'b1)) begin
            n_err++; $display("FAIL b2b_first_value: got an=%b seg=%b want digit of %0d", an, seg, v);
        end
        @(negedge clock);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_gap: got busy=%b want 1 after one idle cycle", busy); end
        count_high(n);
        n_vec++; if (n != CONV_CYCLES) begin n_err++; $display("FAIL b2b_second_len: got %0d want %0d", n, CONV_CYCLES); end
        v = exp_q.pop_front();
        capture_scan(1'b0);
        for (int d = 0; d < 3; d++) begin
            n_vec++; if (obs_seg[d] !== model_seg(v, d, 1'b1)) begin n_err++; $display("FAIL b2b_seg%0d: got %b want %b", d, obs_seg[d], model_seg(v, d, 1'b1)); end
        end
    endtask

    task automatic test_zero();
        bit ok;
        int n;
        int v;
        for (int k = 0; k < 2; k++) begin
            digits = (k == 0) ? 8'd42 : 8'd0;
            exp_q.push_back(int'(digits));
            wait_rise(ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL zero_rise%0d: got busy=0 want busy=1", k); end
            count_high(n);
            n_vec++; if (n != CONV_CYCLES) begin n_err++; $display("FAIL zero_len%0d: got %0d want %0d", k, n, CONV_CYCLES); end
            v = exp_q.pop_front();
            capture_scan(1'b0);
            for (int d = 0; d < 3; d++) begin
                n_vec++; if (obs_seg[d] !== model_seg(v, d, 1'b1)) begin n_err++; $display("FAIL zero_v%0d_seg%0d: got %b want %b", v, d, obs_seg[d], model_seg(v, d, 1'b1)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        int v;
        digits = 8'd100;
        wait_rise(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_rise: got busy=0 want busy=1"); end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_vec++; if (seg !== 7'b1000000) begin n_err++; $display("FAIL rmid_seg: got %b want 1000000", seg); end
        n_vec++; if (an !== 3'b110) begin n_err++; $display("FAIL rmid_an: got %b want 110", an); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(100);
        wait_rise(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_restart: got busy=0 want busy=1"); end
        count_high(n);
        n_vec++; if (n != CONV_CYCLES) begin n_err++; $display("FAIL rmid_len: got %0d want %0d", n, CONV_CYCLES); end
        v = exp_q.pop_front();
        capture_scan(1'b0);
        for (int d = 0; d < 3; d++) begin
            n_vec++; if (obs_seg[d] !== model_seg(v, d, 1'b1)) begin n_err++; $display("FAIL rmid_seg%0d: got %b want %b", d, obs_seg[d], model_seg(v, d, 1'b1)); end
        end
    endtask

    initial begin
        test_reset();
        test_convert_255();
        test_blanking();
        test_back_to_back();
        test_zero();
        test_reset_mid();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
